fp_sumsq_seq: RTL and testbench
===============================

# fp_sumsq_seq

Sequencer that computes the single-precision sum of squares of an operand stream by time-sharing one FP multiplier and one FP adder. Each element is squared on the multiplier, then accumulated on the adder; `in_last` closes the packet and the result is presented on a valid/ready output. It sits between the operand source and the existing combinational fp multiply/add units, which are instantiated beside it at the top level. It generalises the two-operand a²+b² datapath to N operands with one multiplier and one adder.

## Interface
- `FP_W`, 32, IEEE-754 word width; the block is written for 32 only.
- `CNT_W`, 8, width of element counter `out_count`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  FP_W  operand element.
- `in_last`  in  1  marks final element of packet.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block can accept an operand.
- `out_data`  out  FP_W  sum of squares of the packet.
- `out_count`  out  CNT_W  elements in the packet, saturating at 2^CNT_W-1.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `mul_a`, `mul_b`  out  FP_W  multiplier operands.
- `mul_p`  in  FP_W  multiplier product, combinational from `mul_a`/`mul_b`.
- `add_a`, `add_b`  out  FP_W  adder operands.
- `add_s`  in  FP_W  adder sum, combinational from `add_a`/`add_b`.

## Operation
- States: IDLE, SQR, ACC, DONE.
- Registers: `x_reg`, `last_reg`, `prod_reg`, `acc_reg`, `cnt_reg`.
- IDLE: `in_ready`=1. On `in_valid`:
  - `x_reg`<=`in_data`, `last_reg`<=`in_last`.
  - `cnt_reg`<=`cnt_reg`+1, saturating.
  - Next state SQR.
- SQR: `prod_reg`<=`mul_p`; next state ACC.
- ACC: `acc_reg`<=`add_s`. Next state DONE if `last_reg`, else IDLE.
- DONE: `out_valid`=1. On `out_ready`:
  - `acc_reg`<=+0 (0x00000000), `cnt_reg`<=0.
  - Next state IDLE.
- Operand wiring, constant in every state:
  - `mul_a`=`mul_b`=`x_reg`.
  - `add_a`=`acc_reg`, `add_b`=`prod_reg`.
- `out_data`=`acc_reg`; `out_count`=`cnt_reg`.
- No sign/NaN/Inf handling in the block. Special values propagate through the shared units unchanged.
- Squares are non-negative by construction; the sign of `in_data` is irrelevant.
- A single-element packet with `in_last`=1 yields x².
- Reset, including mid-packet:
  - state<=IDLE.
  - `acc_reg`<=+0, `cnt_reg`<=0, `x_reg`<=0, `prod_reg`<=0, `last_reg`<=0.
  - The partial packet is discarded.

## Timing
- Output values after reset: `in_ready`=1, `out_valid`=0, `out_data`=0x00000000, `out_count`=0.
- Mul/add outputs after reset: `mul_a`=`mul_b`=`add_a`=`add_b`=0.
- Throughput: one element per 3 cycles (IDLE accept, SQR, ACC).
- Latency: element accepted at edge T gives SQR in T+1..T+2, ACC in T+2..T+3, `out_valid` high from edge T+3 for a last element.
- `in_ready` is low in SQR, ACC and DONE. `in_valid` in those states is ignored and the operand must be held by the source.
- `out_valid` stays high and `out_data` stays stable until `out_ready`. Back-pressure has no limit.
- `in_ready` rises the cycle after the DONE handshake. Accept and output never overlap in one cycle.
- `in_valid` asserted in the same cycle as the DONE `out_ready` is not accepted that cycle.
- `cnt_reg` saturates at 255 for CNT_W=8 and does not wrap. The accumulation continues past 255 elements.

## Structure
- Shared package `fp_pkg`:
  - `FP_W` = 32.
  - `FP_POS_ZERO` = 32'h00000000.
  - State encoding `sumsq_state_t` {IDLE, SQR, ACC, DONE}.
- Single flat module with one FSM. No sub-module is warranted.
- The fp multiplier and adder are shared resources instantiated at the parent level, not inside this block.

## Test plan
- Packet {4.0=0x40800000, 2.0=0x40000000 last} -> `out_data`=0x41A00000 (20.0), `out_count`=2, `out_valid` 3 cycles after the last accept.
- Packet {10.0=0x41200000, -2.0=0xC0000000 last} -> 0x42D00000 (104.0); confirms sign independence.
- Back-to-back packets {7,2} then {7,3} with `out_ready` held low 5 cycles on the first:
  - First result 0x42540000 (53.0), held stable while `out_ready` is low.
  - Second result 0x42680000 (58.0); the accumulator was cleared between packets.
- Single element {10.0 last} then {4.0 last} -> 0x42C80000 (100.0), then 0x41800000 (16.0), each with `out_count`=1.
- `rst` pulsed during ACC of packet {10,4} -> all outputs at reset values next cycle. Then {10,4} resent -> 0x42E80000 (116.0).
- 300-element packet of 1.0 (0x3F800000) -> `out_count`=255 (saturated), `out_data`=0x43960000 (300.0).

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the sum-of-squares sequencer.
package fp_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } sumsq_state_t;

endpackage

// File: rtl/fp_sumsq_seq.sv
// Sum of squares over an operand packet, time-sharing one external FP multiplier
// and one external FP adder; one element per three cycles.
module fp_sumsq_seq
  import fp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [FP_W-1:0]  out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  mul_a,
  output logic [FP_W-1:0]  mul_b,
  input  logic [FP_W-1:0]  mul_p,
  output logic [FP_W-1:0]  add_a,
  output logic [FP_W-1:0]  add_b,
  input  logic [FP_W-1:0]  add_s
);

  sumsq_state_t     state_reg, state_next;
  logic [FP_W-1:0]  x_reg, x_next;
  logic             last_reg, last_next;
  logic [FP_W-1:0]  prod_reg, prod_next;
  logic [FP_W-1:0]  acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      last_reg  <= 1'b0;
      prod_reg  <= '0;
      acc_reg   <= FP_POS_ZERO;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      last_reg  <= last_next;
      prod_reg  <= prod_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    last_next  = last_reg;
    prod_next  = prod_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_next    = in_data;
          last_next = in_last;
          // Count saturates; the accumulation itself keeps going.
          if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
          state_next = SQR;
        end
      end
      SQR: begin
        prod_next  = mul_p;
        state_next = ACC;
      end
      ACC: begin
        acc_next   = add_s;
        state_next = last_reg ? DONE : IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_next   = FP_POS_ZERO;
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shared-unit operands are static wiring; the FSM only picks when to capture.
  assign mul_a     = x_reg;
  assign mul_b     = x_reg;
  assign add_a     = acc_reg;
  assign add_b     = prod_reg;
  assign out_data  = acc_reg;
  assign out_count = cnt_reg;

endmodule

// File: tb/tb_fp_sumsq_seq.sv
// Bench for fp_sumsq_seq with behavioural FP multiply/add units beside the DUT.
module tb_fp_sumsq_seq;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mul_a, mul_b, mul_p;
  logic [31:0] add_a, add_b, add_s;

  int n_total = 0;
  int n_pass  = 0;

  logic [39:0] exp_q[$];

  fp_sumsq_seq #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Float <-> real conversion, normal numbers and zero only (enough for exact small values).
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(int'(b[22:0])) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real         a;
    int          e;
    logic        s;
    logic [22:0] f;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    f = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  always_comb begin
    mul_p = r2f(f2r(mul_a) * f2r(mul_b));
    add_s = r2f(f2r(add_a) + f2r(add_b));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("send_timeout_in_ready", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for out_valid, optionally stalls `hold` cycles, then handshakes and scores.
  task automatic get_result(input int hold, input int exp_lat);
    int          waited;
    logic [39:0] e;
    waited = 1;
    @(negedge clk);
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      check("result_timeout_out_valid", 32'(out_valid), 32'd1);
      return;
    end
    if (exp_lat > 0) check("latency", 32'(waited), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, e[39:8]);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    // Offer an operand during the handshake; it must not be taken.
    in_valid  = 1'b1;
    in_data   = 32'h40A00000;
    in_last   = 1'b1;
    out_ready = 1'b1;
    check("out_data", out_data, e[39:8]);
    check("out_count", 32'(out_count), 32'(e[7:0]));
    $display("result data=%h count=%0d expected data=%h count=%0d", out_data, out_count, e[39:8], e[7:0]);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    @(negedge clk);
    check("post_handshake_in_ready", 32'(in_ready), 32'd1);
    check("post_handshake_out_valid", 32'(out_valid), 32'd0);
  endtask

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  n;
    logic [31:0] exp_data;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{d0: 32'h40800000, d1: 32'h40000000, n: 2'd2, exp_data: 32'h41A00000, exp_cnt: 8'd2};
    vecs[1] = '{d0: 32'h41200000, d1: 32'hC0000000, n: 2'd2, exp_data: 32'h42D00000, exp_cnt: 8'd2};
    vecs[2] = '{d0: 32'h41200000, d1: 32'h0,        n: 2'd1, exp_data: 32'h42C80000, exp_cnt: 8'd1};
    vecs[3] = '{d0: 32'h40800000, d1: 32'h0,        n: 2'd1, exp_data: 32'h41800000, exp_cnt: 8'd1};
    vecs[4] = '{d0: 32'h40400000, d1: 32'h40800000, n: 2'd2, exp_data: 32'h41C80000, exp_cnt: 8'd2};

    rst = 1'b1; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_out_count", 32'(out_count), 32'd0);
    check("reset_mul_a", mul_a, 32'h0);
    check("reset_mul_b", mul_b, 32'h0);
    check("reset_add_a", add_a, 32'h0);
    check("reset_add_b", add_b, 32'h0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].n == 2'd1) begin
        exp_q.push_back({vecs[v].exp_data, vecs[v].exp_cnt});
        send(vecs[v].d0, 1'b1);
      end else begin
        send(vecs[v].d0, 1'b0);
        exp_q.push_back({vecs[v].exp_data, vecs[v].exp_cnt});
        send(vecs[v].d1, 1'b1);
      end
      get_result(0, 3);
    end

    // Back-to-back packets, first one stalled by the consumer.
    send(32'h40E00000, 1'b0);
    exp_q.push_back({32'h42540000, 8'd2});
    send(32'h40000000, 1'b1);
    get_result(5, 3);
    send(32'h40E00000, 1'b0);
    exp_q.push_back({32'h42680000, 8'd2});
    send(32'h40400000, 1'b1);
    get_result(0, 3);

    // Reset during ACC discards the partial packet.
    send(32'h41200000, 1'b0);
    exp_q.push_back({32'h42E80000, 8'd2});
    send(32'h40800000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    check("midrst_mul_a", mul_a, 32'h0);
    check("midrst_add_b", add_b, 32'h0);
    send(32'h41200000, 1'b0);
    exp_q.push_back({32'h42E80000, 8'd2});
    send(32'h40800000, 1'b1);
    get_result(0, 3);

    // 300 elements of 1.0: count saturates, sum keeps going.
    for (int i = 0; i < 299; i++) send(32'h3F800000, 1'b0);
    exp_q.push_back({32'h43960000, 8'd255});
    send(32'h3F800000, 1'b1);
    get_result(0, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
